// File: rtl/cache_controller_if.sv
// Bundle of pipeline-side and SRAM-side signals for cache_controller.
// The master modport is the environment (MEM stage plus SRAM controller); slave is the cache.
interface cache_controller_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_rd_en;
  logic        sram_wr_en;
  logic [63:0] sram_rdata;
  logic        sram_ready;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  modport master (
    output rd_en, wr_en, address, wdata, sram_rdata, sram_ready,
    input  rdata, ready, sram_address, sram_wdata, sram_rd_en, sram_wr_en, hit_count, miss_count
  );

  modport slave (
    input  rd_en, wr_en, address, wdata, sram_rdata, sram_ready,
    output rdata, ready, sram_address, sram_wdata, sram_rd_en, sram_wr_en, hit_count, miss_count
  );
endinterface

// File: rtl/cache_controller.sv
// 2-way set-associative write-through, no-write-allocate read cache in front of the SRAM controller.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_controller #(
  parameter int unsigned SETS  = 64,
  parameter int unsigned TAG_W = 10
) (
  input logic              clk,
  input logic              rst,
  cache_controller_if.slave bus
);

  localparam int unsigned IDX_W   = $clog2(SETS);
  localparam int unsigned TAG_LSB = 3 + IDX_W;

  typedef enum logic [1:0] {StIdle, StReadMiss, StWrite} state_e;

  state_e state_q, state_d;

  logic [SETS-1:0]  valid_q [2];
  logic [SETS-1:0]  lru_q;
  logic [TAG_W-1:0] tag_q   [2][SETS];
  logic [63:0]      blk_q   [2][SETS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             word_sel;
  logic [1:0]       way_hit;
  logic             hit;
  logic             hit_way;
  logic             victim;
  logic [63:0]      hit_blk;
  logic [31:0]      hit_word;
  logic [31:0]      sram_word;

  logic        ready;
  logic [31:0] rdata;
  logic        sram_rd_en;
  logic        sram_wr_en;
  logic        fill_en;
  logic        upd_en;
  logic        lru_we;
  logic        lru_val;

  assign idx      = bus.address[3 +: IDX_W];
  assign tag      = bus.address[TAG_LSB +: TAG_W];
  assign word_sel = bus.address[2];

  always_comb begin
    way_hit = '0;
    for (int w = 0; w < 2; w++) begin
      way_hit[w] = valid_q[w][idx] && (tag_q[w][idx] == tag);
    end
  end

  assign hit       = |way_hit;
  assign hit_way   = way_hit[1];
  assign hit_blk   = blk_q[hit_way][idx];
  assign hit_word  = word_sel ? hit_blk[63:32] : hit_blk[31:0];
  assign sram_word = word_sel ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];

  // Fill empty ways first so LRU only arbitrates between two live lines.
  assign victim = !valid_q[0][idx] ? 1'b0 :
                  !valid_q[1][idx] ? 1'b1 : lru_q[idx];

  always_comb begin
    state_d    = state_q;
    ready      = 1'b0;
    rdata      = '0;
    sram_rd_en = 1'b0;
    sram_wr_en = 1'b0;
    fill_en    = 1'b0;
    upd_en     = 1'b0;
    lru_we     = 1'b0;
    lru_val    = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.rd_en) begin
          if (hit) begin
            ready   = 1'b1;
            rdata   = hit_word;
            lru_we  = 1'b1;
            lru_val = ~hit_way;
          end else begin
            state_d = StReadMiss;
          end
        end else if (bus.wr_en) begin
          state_d = StWrite;
        end else begin
          ready = 1'b1;
        end
      end
      StReadMiss: begin
        sram_rd_en = 1'b1;
        if (bus.sram_ready) begin
          ready   = 1'b1;
          rdata   = sram_word;
          fill_en = 1'b1;
          lru_we  = 1'b1;
          lru_val = ~victim;
          state_d = StIdle;
        end
      end
      StWrite: begin
        sram_wr_en = 1'b1;
        if (bus.sram_ready) begin
          ready   = 1'b1;
          state_d = StIdle;
          if (hit) begin
            upd_en  = 1'b1;
            lru_we  = 1'b1;
            lru_val = ~hit_way;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
    end else begin
      state_q <= state_d;
      if (fill_en) valid_q[victim][idx] <= 1'b1;
      if (lru_we)  lru_q[idx]           <= lru_val;
    end
  end

  // Tag and data arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[victim][idx] <= tag;
      blk_q[victim][idx] <= bus.sram_rdata;
    end else if (upd_en) begin
      blk_q[hit_way][idx][{word_sel, 5'd0} +: 32] <= bus.wdata;
    end
  end

  assign bus.ready        = ready;
  assign bus.rdata        = rdata;
  assign bus.sram_rd_en   = sram_rd_en;
  assign bus.sram_wr_en   = sram_wr_en;
  assign bus.sram_wdata   = bus.wdata;
  // Reads fetch the whole block, so point at word 0.
  assign bus.sram_address = bus.rd_en ? {bus.address[31:3], 1'b0, bus.address[1:0]} : bus.address;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_q, miss_q;
  logic        hit_done, miss_done;

  assign hit_done  = (state_q == StIdle) && bus.rd_en && hit;
  assign miss_done = (state_q == StReadMiss) && bus.sram_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (hit_done && (hit_q != 16'hFFFF))   hit_q  <= hit_q + 16'd1;
      if (miss_done && (miss_q != 16'hFFFF)) miss_q <= miss_q + 16'd1;
    end
  end

  assign bus.hit_count  = hit_q;
  assign bus.miss_count = miss_q;
`else
  assign bus.hit_count  = '0;
  assign bus.miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed self-checking bench for cache_controller with a variable-latency SRAM model.
module tb_cache_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_controller_if bus ();

  cache_controller #(.SETS(64), .TAG_W(10)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // SRAM model: ready high when idle; with a request, ready in the sram_lat-th request cycle.
  int   sram_lat = 5;
  int   sram_cnt;
  logic sram_req;
  assign sram_req       = bus.sram_rd_en | bus.sram_wr_en;
  assign bus.sram_ready = !sram_req || (sram_cnt >= sram_lat - 1);

  always @(posedge clk or posedge rst) begin
    if (rst)                            sram_cnt <= 0;
    else if (sram_req && !bus.sram_ready) sram_cnt <= sram_cnt + 1;
    else                                sram_cnt <= 0;
  end

  task automatic do_read(input logic [31:0] a, input bit with_wr, output logic [31:0] data,
                         output int waits, output bit used, output logic [31:0] saddr);
    bus.address = a;
    bus.rd_en   = 1'b1;
    bus.wr_en   = with_wr;
    bus.wdata   = 32'hFFFF_0000;
    waits = 0;
    used  = 1'b0;
    saddr = '0;
    #1;
    while (!bus.ready && waits < 50) begin
      if (bus.sram_rd_en) begin used = 1'b1; saddr = bus.sram_address; end
      waits++;
      @(negedge clk);
      #1;
    end
    if (bus.sram_rd_en) begin used = 1'b1; saddr = bus.sram_address; end
    data = bus.rdata;
    @(negedge clk);
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, output int waits,
                          output int wr_cycles, output logic [31:0] saddr,
                          output logic [31:0] sdata);
    bus.address = a;
    bus.wdata   = d;
    bus.rd_en   = 1'b0;
    bus.wr_en   = 1'b1;
    waits     = 0;
    wr_cycles = 0;
    saddr     = '0;
    sdata     = '0;
    #1;
    while (!bus.ready && waits < 50) begin
      if (bus.sram_wr_en) begin
        wr_cycles++; saddr = bus.sram_address; sdata = bus.sram_wdata;
      end
      waits++;
      @(negedge clk);
      #1;
    end
    if (bus.sram_wr_en) wr_cycles++;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.ready !== 1'b1) begin n_bad++;
      $display("FAIL reset_ready: got %b expected 1", bus.ready); end
    n_cmp++; if (bus.rdata !== 32'h0) begin n_bad++;
      $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
    n_cmp++; if ({bus.sram_rd_en, bus.sram_wr_en} !== 2'b00) begin n_bad++;
      $display("FAIL reset_sram_en: got %b expected 00", {bus.sram_rd_en, bus.sram_wr_en}); end
    n_cmp++; if ({bus.hit_count, bus.miss_count} !== 32'h0) begin n_bad++;
      $display("FAIL reset_counts: got %h expected 0", {bus.hit_count, bus.miss_count}); end
    // SRAM ready is high while idle; the cache must not react to it.
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if ({bus.ready, bus.sram_rd_en, bus.sram_wr_en} !== 3'b100) begin n_bad++;
      $display("FAIL idle_stable: got %b expected 100",
               {bus.ready, bus.sram_rd_en, bus.sram_wr_en}); end
    @(negedge clk);
  endtask

  task automatic test_read_miss();
    logic [31:0] d, sa; int w; bit u;
    sram_lat = 5;
    bus.sram_rdata = 64'h2222_2222_1111_1111;
    do_read(32'h10, 1'b0, d, w, u, sa);
    n_cmp++; if (w !== 5) begin n_bad++;
      $display("FAIL miss_latency: got %0d expected 5", w); end
    n_cmp++; if (d !== 32'h1111_1111) begin n_bad++;
      $display("FAIL miss_rdata: got %h expected 11111111", d); end
    n_cmp++; if (u !== 1'b1 || sa !== 32'h10) begin n_bad++;
      $display("FAIL miss_sram_req: got %b/%h expected 1/00000010", u, sa); end
    n_cmp++; if (bus.miss_count !== (STATS ? 16'd1 : 16'd0)) begin n_bad++;
      $display("FAIL miss_count1: got %0d expected %0d", bus.miss_count, STATS ? 1 : 0); end
  endtask

  task automatic test_read_hit();
    logic [31:0] d, sa; int w; bit u;
    do_read(32'h14, 1'b0, d, w, u, sa);
    n_cmp++; if (w !== 0 || u !== 1'b0) begin n_bad++;
      $display("FAIL hit_latency: got %0d/%b expected 0/0", w, u); end
    n_cmp++; if (d !== 32'h2222_2222) begin n_bad++;
      $display("FAIL hit_rdata: got %h expected 22222222", d); end
    n_cmp++; if (bus.hit_count !== (STATS ? 16'd1 : 16'd0)) begin n_bad++;
      $display("FAIL hit_count1: got %0d expected %0d", bus.hit_count, STATS ? 1 : 0); end
  endtask

  task automatic test_lru();
    logic [31:0] d, sa; int w; bit u;
    sram_lat = 2;
    bus.sram_rdata = 64'h4444_4444_3333_3333;
    do_read(32'h210, 1'b0, d, w, u, sa);
    n_cmp++; if (w !== 2 || d !== 32'h3333_3333) begin n_bad++;
      $display("FAIL fill_way1: got %0d/%h expected 2/33333333", w, d); end
    do_read(32'h10, 1'b0, d, w, u, sa);
    n_cmp++; if (w !== 0 || d !== 32'h1111_1111) begin n_bad++;
      $display("FAIL touch_way0: got %0d/%h expected 0/11111111", w, d); end
    bus.sram_rdata = 64'h6666_6666_5555_5555;
    do_read(32'h410, 1'b0, d, w, u, sa);
    n_cmp++; if (w !== 2 || d !== 32'h5555_5555) begin n_bad++;
      $display("FAIL evict_miss: got %0d/%h expected 2/55555555", w, d); end
    do_read(32'h14, 1'b0, d, w, u, sa);
    n_cmp++; if (w !== 0 || d !== 32'h2222_2222) begin n_bad++;
      $display("FAIL mru_kept: got %0d/%h expected 0/22222222", w, d); end
    bus.sram_rdata = 64'h4444_4444_3333_3333;
    do_read(32'h214, 1'b0, d, w, u, sa);
    n_cmp++; if (w !== 2 || d !== 32'h4444_4444 || sa !== 32'h210) begin n_bad++;
      $display("FAIL lru_evicted: got %0d/%h/%h expected 2/44444444/00000210", w, d, sa); end
    n_cmp++; if ({bus.hit_count, bus.miss_count} !== (STATS ? {16'd3, 16'd4} : 32'h0)) begin
      n_bad++;
      $display("FAIL lru_counts: got %0d/%0d expected %0d/%0d", bus.hit_count,
               bus.miss_count, STATS ? 3 : 0, STATS ? 4 : 0); end
  endtask

  task automatic test_write();
    logic [31:0] d, sa, sd; int w, wc; bit u;
    do_write(32'h14, 32'hDEAD_BEEF, w, wc, sa, sd);
    n_cmp++; if (w !== 2 || wc !== 2) begin n_bad++;
      $display("FAIL write_hit_timing: got %0d/%0d expected 2/2", w, wc); end
    n_cmp++; if (sa !== 32'h14 || sd !== 32'hDEAD_BEEF) begin n_bad++;
      $display("FAIL write_sram_bus: got %h/%h expected 00000014/deadbeef", sa, sd); end
    do_read(32'h14, 1'b0, d, w, u, sa);
    n_cmp++; if (w !== 0 || d !== 32'hDEAD_BEEF) begin n_bad++;
      $display("FAIL write_updated: got %0d/%h expected 0/deadbeef", w, d); end
    do_read(32'h10, 1'b0, d, w, u, sa);
    n_cmp++; if (w !== 0 || d !== 32'h1111_1111) begin n_bad++;
      $display("FAIL write_other_word: got %0d/%h expected 0/11111111", w, d); end
    do_write(32'h810, 32'h1234_5678, w, wc, sa, sd);
    n_cmp++; if (w !== 2 || wc !== 2 || sa !== 32'h810) begin n_bad++;
      $display("FAIL write_miss: got %0d/%0d/%h expected 2/2/00000810", w, wc, sa); end
    bus.sram_rdata = 64'h8888_8888_7777_7777;
    do_read(32'h810, 1'b0, d, w, u, sa);
    n_cmp++; if (w !== 2 || u !== 1'b1 || d !== 32'h7777_7777) begin n_bad++;
      $display("FAIL no_allocate: got %0d/%b/%h expected 2/1/77777777", w, u, d); end
    n_cmp++; if ({bus.hit_count, bus.miss_count} !== (STATS ? {16'd5, 16'd5} : 32'h0)) begin
      n_bad++;
      $display("FAIL write_counts: got %0d/%0d expected %0d/%0d", bus.hit_count,
               bus.miss_count, STATS ? 5 : 0, STATS ? 5 : 0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, sa; int w; bit u;
    do_read(32'h14, 1'b0, d, w, u, sa);
    n_cmp++; if (w !== 0 || d !== 32'hDEAD_BEEF) begin n_bad++;
      $display("FAIL b2b_first: got %0d/%h expected 0/deadbeef", w, d); end
    do_read(32'h814, 1'b1, d, w, u, sa);
    n_cmp++; if (w !== 0 || d !== 32'h8888_8888) begin n_bad++;
      $display("FAIL b2b_read_priority: got %0d/%h expected 0/88888888", w, d); end
    do_read(32'h810, 1'b0, d, w, u, sa);
    n_cmp++; if (w !== 0 || d !== 32'h7777_7777) begin n_bad++;
      $display("FAIL b2b_third: got %0d/%h expected 0/77777777", w, d); end
    n_cmp++; if ({bus.hit_count, bus.miss_count} !== (STATS ? {16'd8, 16'd5} : 32'h0)) begin
      n_bad++;
      $display("FAIL b2b_counts: got %0d/%0d expected %0d/%0d", bus.hit_count,
               bus.miss_count, STATS ? 8 : 0, STATS ? 5 : 0); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, sa; int w; bit u;
    sram_lat = 6;
    bus.address = 32'hC10;
    bus.rd_en   = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus.sram_rd_en !== 1'b1) begin n_bad++;
      $display("FAIL mid_in_miss: got %b expected 1", bus.sram_rd_en); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({bus.sram_rd_en, bus.sram_wr_en} !== 2'b00) begin n_bad++;
      $display("FAIL mid_rst_drop: got %b expected 00", {bus.sram_rd_en, bus.sram_wr_en}); end
    bus.rd_en = 1'b0;
    #1;
    n_cmp++; if (bus.ready !== 1'b1 || bus.rdata !== 32'h0) begin n_bad++;
      $display("FAIL mid_rst_idle: got %b/%h expected 1/00000000", bus.ready, bus.rdata); end
    @(negedge clk);
    rst = 1'b0;
    sram_lat = 2;
    bus.sram_rdata = 64'hABCD_0002_ABCD_0001;
    do_read(32'h14, 1'b0, d, w, u, sa);
    n_cmp++; if (w !== 2 || u !== 1'b1 || d !== 32'hABCD_0002) begin n_bad++;
      $display("FAIL mid_invalidated: got %0d/%b/%h expected 2/1/abcd0002", w, u, d); end
    n_cmp++; if ({bus.hit_count, bus.miss_count} !== (STATS ? {16'd0, 16'd1} : 32'h0)) begin
      n_bad++;
      $display("FAIL mid_counts: got %0d/%0d expected %0d/%0d", bus.hit_count,
               bus.miss_count, 0, STATS ? 1 : 0); end
  endtask

  task automatic test_counters();
`ifdef CACHE_STATS_EN
    bus.address = 32'h14;
    bus.rd_en   = 1'b1;
    repeat (65536) @(negedge clk);
    #1;
    n_cmp++; if (bus.rdata !== 32'hABCD_0002) begin n_bad++;
      $display("FAIL sat_rdata: got %h expected abcd0002", bus.rdata); end
    n_cmp++; if (bus.hit_count !== 16'hFFFF) begin n_bad++;
      $display("FAIL sat_hit: got %h expected ffff", bus.hit_count); end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (bus.hit_count !== 16'hFFFF || bus.miss_count !== 16'd1) begin n_bad++;
      $display("FAIL sat_hold: got %h/%0d expected ffff/1", bus.hit_count, bus.miss_count); end
    @(negedge clk);
    bus.rd_en = 1'b0;
`else
    logic [31:0] d, sa; int w; bit u;
    for (int i = 0; i < 4; i++) begin
      do_read(32'h14, 1'b0, d, w, u, sa);
      n_cmp++; if (w !== 0 || bus.hit_count !== 16'd0 || bus.miss_count !== 16'd0) begin
        n_bad++;
        $display("FAIL counters_tied: got %0d/%0d/%0d expected 0/0/0", w, bus.hit_count,
                 bus.miss_count); end
    end
`endif
  endtask

  initial begin
    rst            = 1'b1;
    bus.rd_en      = 1'b0;
    bus.wr_en      = 1'b0;
    bus.address    = '0;
    bus.wdata      = '0;
    bus.sram_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_lru();
    test_write();
    test_back_to_back();
    test_reset_mid();
    test_counters();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- 2-way set-associative, write-through, no-write-allocate read cache between the MEM pipeline stage and the SRAM controller.
- Read hits return in 0 wait cycles. Read misses fetch one 64-bit block (two 32-bit words) from the SRAM controller and fill the victim way.
- Writes always pass through to SRAM. On a write hit the cached copy is updated as well.
- The single `ready` output is the freeze signal for the pipeline.

Parameters:
- SETS, 64, number of sets; index width = log2(SETS) = 6.
- TAG_W, 10, tag width; address bits [18:9].

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rd_en  in  1  read request from MEM stage
- wr_en  in  1  write request from MEM stage
- address  in  32  byte address; bit[2] = word select, [8:3] = index, [18:9] = tag; bits [1:0] and [31:19] ignored
- wdata  in  32  store data
- rdata  out  32  load data; valid when ready=1 and rd_en=1
- ready  out  1  1 = request complete / idle; 0 = freeze pipeline
- sram_address  out  32  address forwarded to SRAM controller; equals address with bit[2] forced to 0 on reads
- sram_wdata  out  32  equals wdata
- sram_rd_en  out  1  SRAM read request
- sram_wr_en  out  1  SRAM write request
- sram_rdata  in  64  block from SRAM; [31:0] = word 0, [63:32] = word 1
- sram_ready  in  1  SRAM access complete; only sampled while a request is asserted
- hit_count  out  16  hits counter (see Optional Feature)
- miss_count  out  16  misses counter (see Optional Feature)

Behaviour:
- Storage per set:
  - per way: valid bit, TAG_W tag, two 32-bit words;
  - one LRU bit, holding the index of the way to evict next.
- Hit rule: way w hits when valid[w] is set and tag[w] == address[18:9]. At most one way can hit.
- Requester protocol: holds rd_en/wr_en, address and wdata stable until it samples ready=1. If rd_en and wr_en are both asserted, the read takes priority and the write is ignored.
- FSM states: IDLE, READ_MISS, WRITE.
- IDLE:
  - No request: ready=1, sram_rd_en=0, sram_wr_en=0, rdata=0.
  - Read hit: ready=1 combinationally in the same cycle; rdata = hit word selected by address[2]; no SRAM access. On the clock edge, LRU <= ~hit_way.
  - Read miss: ready=0; move to READ_MISS.
  - Write: ready=0; move to WRITE.
- READ_MISS:
  - sram_rd_en=1 while in this state.
  - When sram_ready=1:
    - rdata = sram_rdata word selected by address[2]; ready=1 in that same cycle.
    - On the edge: write tag, valid and both words into the victim way; LRU <= ~victim; state -> IDLE.
  - Victim choice: way0 if invalid; else way1 if invalid; else the way named by LRU.
- WRITE:
  - sram_wr_en=1 while in this state.
  - When sram_ready=1: ready=1.
    - On a write hit, the edge writes wdata into the hit way's selected word and sets LRU <= ~hit_way.
    - On a miss, no fill or allocation.
    - State -> IDLE.
- Back-to-back requests: a new request is evaluated in IDLE the cycle after completion. Worst-case miss latency = SRAM latency + 1 cycle.
- Reset, including mid-transaction: state=IDLE, all valid bits=0, all LRU bits=0, sram_rd_en=0, sram_wr_en=0, counters=0. Tag and data arrays need no reset.
- Outputs after reset with no request: ready=1, rdata=0.
- sram_ready is ignored in IDLE. This matters because the SRAM controller drives its ready high whenever it is idle.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - hit_count increments by 1 on each read-hit completion.
  - miss_count increments by 1 on each read-miss completion.
  - Both are 16-bit and saturate at 0xFFFF. Writes are not counted.
- Undefined: hit_count and miss_count are tied to 0 and no counter registers are synthesized.

Test Plan:
- After reset, read 0x00000010 (set 2, tag 0) with sram_rdata=0x22222222_11111111 after a 5-cycle SRAM delay -> ready=0 for 5 cycles, then rdata=0x11111111 with ready=1; way0 filled; miss_count=1.
- Immediately read 0x00000014 -> same-cycle ready=1, rdata=0x22222222, sram_rd_en stays 0; hit_count=1.
- Fill 0x210 (way1), touch 0x10, then read-miss 0x410 -> way1 (LRU) evicted. A later read of 0x10 hits; a later read of 0x210 misses.
- Write 0xDEADBEEF to 0x14 (hit) -> sram_wr_en=1 until sram_ready, then ready=1. A subsequent read of 0x14 hits and returns 0xDEADBEEF. A write to 0x810 (miss) causes no allocation: reading 0x810 afterwards misses.
- Assert rst during READ_MISS -> sram_rd_en drops immediately; a previously cached address now misses.
- With CACHE_STATS_EN, 0x10000 hits -> hit_count stays at 0xFFFF. Without the macro, both counters read 0 throughout.
